// File: rtl/collector_drain_pkg.sv
// Shared types and sizing for the collector FIFO drain: state encoding and
// the depth/occupancy width of the read-latency buffer.
package collector_drain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } drain_state_t;

   localparam int DRAIN_DEPTH = 4;
   // Occupancy must represent 0..DEPTH inclusive.
   localparam int DRAIN_OCC_W = $clog2(DRAIN_DEPTH + 1);

endpackage

// File: rtl/drain_sync_fifo.sv
// Small register-based FIFO whose head is visible combinationally, so the
// stream output sees the oldest entry in the same cycle occupancy becomes nonzero.
module drain_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int OCC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [OCC_W-1:0] occ
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] occ_reg;
   logic [WIDTH-1:0] entry [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] data_reg;
         always_ff @(posedge clk) begin
            if (!rst) begin
               data_reg <= '0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               data_reg <= push_data;
            end
         end
         assign entry[gi] = data_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + 1'b1;
            2'b01:   occ_reg <= occ_reg - 1'b1;
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   assign head = entry[rd_ptr_reg];
   assign occ  = occ_reg;

endmodule

// File: rtl/collector_axis_drain.sv
// Drains the MLP collector output FIFO into an AXI-Stream master with framed tlast.
// Optional statistics counters are built when COLLECTOR_DRAIN_STATS_EN is defined.
module collector_axis_drain
   import collector_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int FRAME_LEN  = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  collector_ofifo_rdy,
   output logic                  collector_ofifo_ren,
   input  logic [DATA_WIDTH-1:0] collector_ofifo_rdata,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  frame_done
`ifdef COLLECTOR_DRAIN_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic [CNT_WIDTH-1:0]  frame_count
`endif
);

   localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
   localparam logic [DRAIN_OCC_W:0] DEPTH_LIMIT = (DRAIN_OCC_W + 1)'(DRAIN_DEPTH);

   generate
      if ((FRAME_LEN < 1) || (CNT_WIDTH < 1)) begin : g_bad_params
         $error("collector_axis_drain: FRAME_LEN and CNT_WIDTH must be >= 1");
      end
   endgenerate

   drain_state_t           state_reg;
   drain_state_t           state_next;
   logic                   inflight_reg;
   logic [BEAT_W-1:0]      beat_reg;
   logic                   frame_done_reg;
   logic [DRAIN_OCC_W-1:0] occ;
   logic                   pop;
   logic [DRAIN_OCC_W:0]   pending;

   drain_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DRAIN_DEPTH),
      .OCC_W (DRAIN_OCC_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_reg),
      .push_data (collector_ofifo_rdata),
      .pop       (pop),
      .head      (m_axis_tdata),
      .occ       (occ)
   );

   assign m_axis_tvalid = (occ != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign m_axis_tlast  = m_axis_tvalid && (beat_reg == BEAT_LAST);
   assign frame_done    = frame_done_reg;

   // Count the in-flight word as already occupying a slot so the buffer can never overflow.
   assign pending = {1'b0, occ} + {{DRAIN_OCC_W{1'b0}}, inflight_reg}
                  - {{DRAIN_OCC_W{1'b0}}, pop};

   assign collector_ofifo_ren = rst && (state_reg == RUN) && collector_ofifo_rdy
                              && (pending < DEPTH_LIMIT);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (!enable) state_next = STOP;
         STOP: begin
            if (enable) begin
               state_next = RUN;
            end else if ((occ == '0) && !inflight_reg) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         inflight_reg   <= 1'b0;
         beat_reg       <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         inflight_reg   <= collector_ofifo_ren;
         frame_done_reg <= pop && m_axis_tlast;
         // Beat position survives enable pauses so a frame resumes where it stopped.
         if (pop) begin
            beat_reg <= (beat_reg == BEAT_LAST) ? '0 : beat_reg + 1'b1;
         end
      end
   end

`ifdef COLLECTOR_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] word_count_reg;
   logic [CNT_WIDTH-1:0] frame_count_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         word_count_reg  <= '0;
         frame_count_reg <= '0;
      end else if (pop) begin
         word_count_reg <= word_count_reg + 1'b1;
         if (m_axis_tlast) begin
            frame_count_reg <= frame_count_reg + 1'b1;
         end
      end
   end

   assign word_count  = word_count_reg;
   assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_collector_axis_drain.sv
// Self-checking bench for collector_axis_drain: directed scenarios plus a random
// phase, all compared against a queue-based model of the source and stream.
module tb_collector_axis_drain;

    localparam int DW        = 64;
    localparam int FRAME_LEN = 16;
    localparam int CW        = 32;
    localparam int DEPTH     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          rdy;
    logic          ren;
    logic [DW-1:0] rdata;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          frame_done;
`ifdef COLLECTOR_DRAIN_STATS_EN
    logic [CW-1:0] word_count;
    logic [CW-1:0] frame_count;
`endif

    always #5 clk = ~clk;

    collector_axis_drain #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FRAME_LEN),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable                (enable),
        .collector_ofifo_rdy   (rdy),
        .collector_ofifo_ren   (ren),
        .collector_ofifo_rdata (rdata),
        .m_axis_tdata          (tdata),
        .m_axis_tvalid         (tvalid),
        .m_axis_tready         (tready),
        .m_axis_tlast          (tlast),
        .frame_done            (frame_done)
`ifdef COLLECTOR_DRAIN_STATS_EN
        ,
        .word_count            (word_count),
        .frame_count           (frame_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        int            issue;
    } word_t;

    // Words handed out by the source and not yet accepted downstream, oldest first.
    word_t         exp_q[$];
    int            cyc = 0;
    int            beats = 0;
    bit            run_exp = 0;
    bit            fd_exp = 0;
    bit            dut_live = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] tdata_prev = '0;
    bit            have_rd = 0;
    logic [DW-1:0] rd_word = '0;
    bit            rand_data = 0;
    logic [DW-1:0] seq = '0;
    logic [CW-1:0] wc_exp = '0;
    logic [CW-1:0] fc_exp = '0;

    int            n_assert = 0;
    int            n_fail = 0;

    int            issued = 0;
    int            first_ren = -1;
    int            first_val = -1;
    int            pop_first = -1;
    int            pop_last = -1;
    int            npops = 0;
    int            fd_cnt = 0;
    logic [DW-1:0] tlast_vals[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit            tv_exp;
        bit            tl_exp;
        bit            ren_exp;
        bit            pop_now;
        bit            ren_seen;
        int            outstanding;
        word_t         w;
        #1;
        pop_now  = 1'b0;
        tl_exp   = 1'b0;
        ren_seen = (ren === 1'b1);
        if (dut_live) begin
            outstanding = exp_q.size();
            tv_exp = (outstanding != 0) && ((cyc - exp_q[0].issue) >= 2);
            check("tvalid", tvalid, tv_exp);
            if (tv_exp) begin
                tl_exp = ((beats % FRAME_LEN) == FRAME_LEN - 1);
                check("tdata", tdata, exp_q[0].data);
                check("tlast", tlast, tl_exp);
                if (stall_prev) check("tdata_hold", tdata, tdata_prev);
            end
            pop_now = tv_exp && tready;
            ren_exp = rst && run_exp && rdy && ((outstanding - int'(pop_now)) < DEPTH);
            check("ren", ren, ren_exp);
            check("frame_done", frame_done, fd_exp);
`ifdef COLLECTOR_DRAIN_STATS_EN
            check("word_count", word_count, wc_exp);
            check("frame_count", frame_count, fc_exp);
`endif
            stall_prev = tv_exp && !tready;
            tdata_prev = tdata;
            if (ren_seen && first_ren < 0) first_ren = cyc;
            if (tvalid === 1'b1 && first_val < 0) first_val = cyc;
            if (tvalid === 1'b1 && tready) begin
                if (pop_first < 0) pop_first = cyc;
                pop_last = cyc;
                npops++;
                if (tlast === 1'b1) tlast_vals.push_back(tdata);
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            beats      = 0;
            fd_exp     = 0;
            run_exp    = 0;
            wc_exp     = '0;
            fc_exp     = '0;
            stall_prev = 0;
            have_rd    = 0;
            dut_live   = 1;
        end else if (dut_live) begin
            if (pop_now) begin
                void'(exp_q.pop_front());
                beats++;
                wc_exp++;
                if (tl_exp) fc_exp++;
            end
            fd_exp = pop_now && tl_exp;
            have_rd = ren_seen;
            if (ren_seen) begin
                w.data  = rand_data ? {$urandom, $urandom} : seq;
                w.issue = cyc;
                seq++;
                issued++;
                exp_q.push_back(w);
                rd_word = w.data;
            end
            run_exp = enable;
        end
        cyc++;
        #1;
        rdata = have_rd ? rd_word : {$urandom, $urandom};
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        rdy    = 1'b1;
        tready = 1'b0;
        rdata  = '0;
        @(negedge clk);

        // Reset held with a ready source: nothing may be read or presented.
        repeat (5) tick();
        check("rst_tdata", tdata, 64'd0);
        check("rst_tlast", tlast, 1'b0);
        rst = 1'b1;
        tick();

        // Streaming 0..31 with everything open.
        seq = '0; issued = 0; first_ren = -1; first_val = -1;
        pop_first = -1; pop_last = -1; npops = 0; fd_cnt = 0;
        tlast_vals.delete();
        enable = 1'b1; tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy = (issued < 32);
            tick();
        end
        check("stream_latency", first_val - first_ren, 2);
        check("stream_beats", npops, 32);
        check("stream_back2back", pop_last - pop_first, 31);
        check("stream_tlast_n", tlast_vals.size(), 2);
        check("stream_tlast0", (tlast_vals.size() > 0) ? tlast_vals[0] : '1, 64'd15);
        check("stream_tlast1", (tlast_vals.size() > 1) ? tlast_vals[1] : '1, 64'd31);
        check("stream_frames", fd_cnt, 2);
`ifdef COLLECTOR_DRAIN_STATS_EN
        check("stream_frame_count", frame_count, 32'd2);
`endif

        // Backpressure mid-stream.
        rdy = 1'b1; tready = 1'b1;
        repeat (5) tick();
        tready = 1'b0;
        repeat (10) tick();
        check("bp_ren_low", ren, 1'b0);
        check("bp_buffered", exp_q.size() <= DEPTH, 1'b1);
        tready = 1'b1;
        repeat (6) tick();
        rdy = 1'b0;
        repeat (8) tick();

        // Enable pause after five reads, then resume mid-frame.
        issued = 0; rdy = 1'b1; enable = 1'b1;
        for (int i = 0; i < 20 && issued < 5; i++) tick();
        enable = 1'b0;
        repeat (12) tick();
        check("pause_empty", tvalid, 1'b0);
        enable = 1'b1;
        repeat (20) tick();
        rdy = 1'b0;
        repeat (8) tick();

        // Sparse source: rdy alternates every cycle.
        for (int i = 0; i < 40; i++) begin
            rdy = i[0];
            tick();
        end
        rdy = 1'b0;
        repeat (8) tick();

        // Reset mid-frame at beat 7 with words buffered.
        rdy = 1'b1; tready = 1'b1;
        for (int i = 0; i < 100 && (beats % FRAME_LEN) != 7; i++) tick();
        tready = 1'b0;
        repeat (3) tick();
        check("mid_beat7", beats % FRAME_LEN, 7);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_flush", tvalid, 1'b0);
        tready = 1'b1;
        repeat (24) tick();

        // Random traffic with occasional resets.
        rand_data = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            rdy    = ($urandom_range(0, 3) != 0);
            tready = ($urandom_range(0, 2) != 0);
            rst    = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1; enable = 1'b0; rdy = 1'b0; tready = 1'b1;
        repeat (12) tick();
        check("final_drained", tvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/collector_axis_drain.md
# collector_axis_drain

Downstream consumer of the `mlp_1` collector output FIFO.
- Issues read enables against the FIFO's ready flag and absorbs the one-cycle read latency in a small buffer.
- Re-presents the results as an AXI-Stream master, marking `tlast` every `FRAME_LEN` beats.
- Sits between the MLP collector and the NoC egress / result sink; it is the mirror image of the dispatcher-side traffic generators.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of FIFO read data and stream data
- `FRAME_LEN`, 16, beats per output frame (≥1)
- `CNT_WIDTH`, 32, width of statistics counters

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst`  in  1  reset, synchronous and active-low
- `enable`  in  1  when high, new FIFO reads may be issued
- `collector_ofifo_rdy`  in  1  collector FIFO non-empty
- `collector_ofifo_ren`  out  1  FIFO read enable; one word per high cycle
- `collector_ofifo_rdata`  in  DATA_WIDTH  FIFO data, valid the cycle after `ren`
- `m_axis_tdata`  out  DATA_WIDTH  stream data
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `m_axis_tlast`  out  1  last beat of frame
- `frame_done`  out  1  one-cycle pulse after a `tlast` beat completes
- `word_count`  out  CNT_WIDTH  accepted output beats (macro only)
- `frame_count`  out  CNT_WIDTH  completed frames (macro only)

## Operation
- Buffer: 4-entry FIFO (`DEPTH`=4). `occ` counts stored entries. `inflight` is 1 when `ren` was high in the previous cycle.
- Read issue rule (combinational): `ren = rst && state==RUN && collector_ofifo_rdy && (occ + inflight - pop) < DEPTH`, where `pop = tvalid && tready`. This rule guarantees the buffer never overflows.
- Capture: when `inflight`=1, `collector_ofifo_rdata` is written into the buffer at the end of that cycle.
- Output: `tvalid = (occ != 0)`. `tdata` is the buffer head. `tdata` and `tlast` stay stable while `tvalid && !tready`.
- Beat counter `beat` (0..FRAME_LEN-1):
  - increments on each `pop`, wrapping to 0 after FRAME_LEN-1;
  - `tlast = (beat == FRAME_LEN-1)`; with FRAME_LEN=1, `tlast` is always 1.
- FSM states and transitions:
  - IDLE → RUN when `enable`=1.
  - RUN → STOP when `enable`=0.
  - STOP → RUN when `enable`=1.
  - STOP → IDLE when `occ`=0 and `inflight`=0.
  - In STOP, no new reads are issued, in-flight data is still captured, and the buffer keeps draining.
- `beat` is not reset by STOP/IDLE. A frame spanning an enable pause continues its count.
- Simultaneous push and pop in the same cycle: `occ` is unchanged.

## Timing
- Reset (`rst`=0 at an edge), values the cycle after:
  - state=IDLE, `occ`=0, `inflight`=0, `beat`=0;
  - `ren`=0, `tvalid`=0, `tlast`=0, `tdata`=0, `frame_done`=0;
  - counters 0.
- Reset mid-operation flushes the buffer; any in-flight word is discarded.
- Latency: `ren` high in cycle k → data written at the end of k+1 → `tvalid` high in k+2.
- Throughput: 1 beat/cycle sustained with `tready`=1 and `rdy`=1.
- `frame_done` is registered: high in the cycle after the `tlast` handshake, for exactly one cycle.
- Counters:
  - `word_count` increments on every `pop`;
  - `frame_count` increments on every `tlast` pop;
  - both wrap modulo 2^CNT_WIDTH.

## Configuration
- `COLLECTOR_DRAIN_STATS_EN` defined: the `word_count` and `frame_count` ports and their registers exist.
- Not defined: both ports and counters are absent. `frame_done` and all other behaviour are identical in both builds.

## Structure
- Package `collector_drain_pkg` holds:
  - the state enum `drain_state_t` {IDLE, RUN, STOP};
  - `DRAIN_DEPTH`=4;
  - the occupancy width constant.
- Sub-module `drain_sync_fifo` (parameterised width/depth, push/pop/occ) is instantiated once for the buffer.
- The FSM, read-issue logic and beat/stat counters live in the top module.

## Test plan
- Reset: hold `rst`=0 for 5 cycles with `rdy`=1 → `ren`=0, `tvalid`=0, `frame_done`=0 throughout and the cycle after release.
- Streaming: `enable`=1, `rdy`=1, `tready`=1, FIFO yields 0..31, FRAME_LEN=16 →
  - `ren` in cycle 0, first `tvalid` in cycle 2;
  - 32 consecutive beats in order;
  - `tlast` on values 15 and 31, `frame_done` pulses the cycle after each;
  - `frame_count`=2.
- Backpressure: `tready`=0 for 10 cycles mid-stream → at most 4 words buffered, `ren` drops, `tdata` held stable, no data lost or duplicated.
- Enable pause: drop `enable` after 5 reads → in-flight word still delivered, state reaches IDLE. Re-enabling resumes with `beat`=5, so `tlast` falls on the 16th beat overall.
- Empty source: `rdy` toggles 1/0 every cycle → `ren` only in `rdy` cycles, output order preserved.
- Reset mid-frame at beat 7 with 3 words buffered → buffer emptied, `tvalid`=0 the next cycle, the following frame's `tlast` is at its 16th beat.
